// File: rtl/output_deskewer.sv
// Output deskewer for a systolic array.
// Lane j is delayed by MATRIX_SIZE-1-j stages so that the diagonal wavefront
// leaving the array lines up as one word per row. The block also counts rows
// per matrix, pulses done after the last row, and latches a sticky error if
// the delayed lane valids ever disagree.
module output_deskewer #(
    parameter int unsigned MATRIX_SIZE = 2,
    parameter int unsigned DATA_SIZE   = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  enable_in,
    input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] data_in,
    input  logic [MATRIX_SIZE-1:0]                valid_in,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] data_out,
    output logic                                  valid_out,
    output logic [((MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1)-1:0] row_idx,
    output logic                                  last_row,
    output logic                                  done,
    output logic                                  misalign_err
);

    localparam int unsigned RowW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
    localparam logic [RowW-1:0] LastRow = RowW'(MATRIX_SIZE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDone
    } state_e;

    // Lane values presented to the output register (after their delay lines).
    logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] w_lane_data;
    logic [MATRIX_SIZE-1:0]                w_lane_valid;
    logic                                  w_av;
    logic                                  w_any;
    logic                                  w_emit;
    logic                                  w_last;
    state_e                                w_state_d;
    logic [RowW-1:0]                       w_cnt_d;

    state_e                                r_state;
    logic [RowW-1:0]                       r_cnt;
    logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] r_data_out;
    logic                                  r_valid_out;
    logic [RowW-1:0]                       r_row_idx;
    logic                                  r_last_row;
    logic                                  r_done;
    logic                                  r_err;

    for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_lane
        localparam int Depth = int'(MATRIX_SIZE) - 1 - j;
        if (Depth == 0) begin : g_direct
            assign w_lane_data[j]  = data_in[j];
            assign w_lane_valid[j] = valid_in[j];
        end else begin : g_delay
            logic [Depth-1:0][DATA_SIZE-1:0] r_sdata;
            logic [Depth-1:0]                r_svalid;

            // Delay line for this lane; frozen while the array is stalled.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_sdata  <= '0;
                    r_svalid <= '0;
                end else if (enable_in) begin
                    r_sdata[0]  <= data_in[j];
                    r_svalid[0] <= valid_in[j];
                    for (int k = 1; k < Depth; k++) begin
                        r_sdata[k]  <= r_sdata[k-1];
                        r_svalid[k] <= r_svalid[k-1];
                    end
                end
            end

            assign w_lane_data[j]  = r_sdata[Depth-1];
            assign w_lane_valid[j] = r_svalid[Depth-1];
        end
    end

    assign w_av  = &w_lane_valid;
    assign w_any = |w_lane_valid;

    // Next-state logic: row accepted on an aligned valid; DONE lasts one enabled cycle.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_emit    = 1'b0;
        w_last    = 1'b0;
        if (enable_in) begin
            w_emit = w_av;
            unique case (r_state)
                StIdle, StCollect: begin
                    if (w_av) begin
                        w_state_d = (r_cnt == LastRow) ? StDone : StCollect;
                    end
                end
                StDone: begin
                    if (!w_av) begin
                        w_state_d = StIdle;
                    end else begin
                        w_state_d = (r_cnt == LastRow) ? StDone : StCollect;
                    end
                end
                default: w_state_d = StIdle;
            endcase
            if (w_av) begin
                if (r_cnt == LastRow) begin
                    w_last  = 1'b1;
                    w_cnt_d = '0;
                end else begin
                    w_cnt_d = r_cnt + RowW'(1);
                end
            end
        end
    end

    // FSM state and row counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Registered outputs; data_out and row_idx hold between emitted rows.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_row_idx   <= '0;
            r_last_row  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_valid_out <= w_emit;
            r_last_row  <= w_last;
            r_done      <= enable_in && (r_state == StDone);
            if (w_emit) begin
                r_data_out <= w_lane_data;
                r_row_idx  <= r_cnt;
            end
            if (enable_in && w_any && !w_av) begin
                r_err <= 1'b1;
            end
        end
    end

    assign data_out     = r_data_out;
    assign valid_out    = r_valid_out;
    assign row_idx      = r_row_idx;
    assign last_row     = r_last_row;
    assign done         = r_done;
    assign misalign_err = r_err;

endmodule

// File: tb/tb_output_deskewer.sv
// Bench for output_deskewer (N=4): directed scenarios with literal expectations
// followed by randomized streams checked every cycle against a behavioural model.
module tb_output_deskewer;

    localparam int N  = 4;
    localparam int DW = 32;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   enable_in;
    logic [N-1:0][DW-1:0]   data_in;
    logic [N-1:0]           valid_in;
    logic [N-1:0][DW-1:0]   data_out;
    logic                   valid_out;
    logic [1:0]             row_idx;
    logic                   last_row;
    logic                   done;
    logic                   misalign_err;

    output_deskewer #(
        .MATRIX_SIZE(N),
        .DATA_SIZE  (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable_in   (enable_in),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .row_idx     (row_idx),
        .last_row    (last_row),
        .done        (done),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Logical rows: the bench skews them itself (row r on lane j at step r+j).
    logic [DW-1:0] rd [64][N];
    bit            rv [64];
    logic [N-1:0]  rmask [64];
    int            n_rows = 0;
    int            s = 0;

    task automatic set_rows(input int n, input logic [DW-1:0] base);
        n_rows = n;
        for (int r = 0; r < n; r++) begin
            for (int j = 0; j < N; j++) rd[r][j] = base + DW'(r * 256 + j);
            rv[r]    = 1'b1;
            rmask[r] = '1;
        end
    endtask

    task automatic drive(input bit rst_n, input bit en);
        reset     = rst_n;
        enable_in = en;
        for (int j = 0; j < N; j++) begin
            int r;
            r = s - j;
            if (r >= 0 && r < n_rows) begin
                data_in[j]  = rd[r][j];
                valid_in[j] = rv[r] & rmask[r][j];
            end else begin
                data_in[j]  = '0;
                valid_in[j] = 1'b0;
            end
        end
        @(posedge clk);
        if (!rst_n) s = 0;
        else if (en) s++;
        @(negedge clk);
    endtask

    // Behavioural model: lane j sees its input from N-1-j enabled steps ago.
    typedef struct packed {
        logic [N-1:0][DW-1:0] d;
        logic [N-1:0]         v;
    } step_t;

    step_t                m_q[$];
    logic [N-1:0][DW-1:0] m_data;
    logic                 m_valid, m_last, m_done, m_err, m_pend;
    logic [1:0]           m_idx;
    int                   m_rows;

    always @(posedge clk) begin
        step_t                cur;
        logic                 av, any;
        logic [N-1:0][DW-1:0] row;
        if (!reset) begin
            m_q.delete();
            for (int k = 0; k < N - 1; k++) m_q.push_back('0);
            m_data = '0; m_valid = 0; m_last = 0; m_done = 0; m_err = 0; m_pend = 0;
            m_idx = '0; m_rows = 0;
        end else if (enable_in) begin
            cur.d = data_in;
            cur.v = valid_in;
            av  = 1'b1;
            any = 1'b0;
            for (int j = 0; j < N; j++) begin
                logic lv;
                if (j < N - 1) begin
                    row[j] = m_q[j].d[j];
                    lv     = m_q[j].v[j];
                end else begin
                    row[j] = cur.d[j];
                    lv     = cur.v[j];
                end
                av  = av & lv;
                any = any | lv;
            end
            m_q.push_back(cur);
            void'(m_q.pop_front());
            if (any && !av) m_err = 1'b1;
            m_done  = m_pend;
            m_pend  = 1'b0;
            m_valid = av;
            m_last  = 1'b0;
            if (av) begin
                m_data = row;
                m_idx  = 2'(m_rows % N);
                m_last = (m_rows % N) == N - 1;
                m_pend = m_last;
                m_rows++;
            end
        end else begin
            m_valid = 1'b0;
            m_last  = 1'b0;
            m_done  = 1'b0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model data_out", data_out, m_data);
            chk("model valid_out", 128'(valid_out), 128'(m_valid));
            chk("model row_idx", 128'(row_idx), 128'(m_idx));
            chk("model last_row", 128'(last_row), 128'(m_last));
            chk("model done", 128'(done), 128'(m_done));
            chk("model misalign_err", 128'(misalign_err), 128'(m_err));
        end
    end

    initial begin
        reset = 1'b0; enable_in = 1'b0; data_in = '0; valid_in = '0;
        drive(0, 0);
        drive(0, 1);
        chk_on = 1'b1;
        chk("reset data_out", data_out, '0);
        chk("reset flags", 128'({valid_out, last_row, done, misalign_err, row_idx}), '0);

        // Two matrices back-to-back, no stalls.
        set_rows(8, 32'h0);
        drive(0, 1);
        for (int k = 1; k <= 12; k++) begin
            drive(1, 1);
            if (k == 3) chk("a3 valid_out", 128'(valid_out), 0);
            if (k == 4) begin
                chk("a4 valid_out", 128'(valid_out), 1);
                chk("a4 row_idx", 128'(row_idx), 0);
                chk("a4 data_out", data_out, 128'h00000003_00000002_00000001_00000000);
            end
            if (k == 7) chk("a7 last/idx", 128'({last_row, row_idx}), 128'b1_11);
            if (k == 8) begin
                chk("a8 done", 128'(done), 1);
                chk("a8 valid/idx", 128'({valid_out, row_idx}), 128'b1_00);
                chk("a8 data_out", data_out, 128'h00000403_00000402_00000401_00000400);
            end
            if (k == 11) chk("a11 last/idx", 128'({last_row, row_idx}), 128'b1_11);
            if (k == 12) chk("a12 done/valid", 128'({done, valid_out}), 128'b10);
        end

        // Three-cycle stall in the middle of a row.
        set_rows(1, 32'hA0);
        drive(0, 1);
        drive(1, 1); drive(1, 1);
        drive(1, 0); drive(1, 0); drive(1, 0);
        chk("b stall valid", 128'(valid_out), 0);
        chk("b stall data", data_out, '0);
        drive(1, 1);
        chk("b6 valid", 128'(valid_out), 0);
        drive(1, 1);
        chk("b7 valid", 128'(valid_out), 1);
        chk("b7 data", data_out, 128'h000000A3_000000A2_000000A1_000000A0);
        drive(1, 1);
        chk("b8 valid", 128'(valid_out), 0);
        chk("b8 data hold", data_out, 128'h000000A3_000000A2_000000A1_000000A0);

        // Lane 3 valid withheld: sticky misalignment, no row.
        set_rows(1, 32'hC0);
        rmask[0] = 4'b0111;
        drive(0, 1);
        for (int k = 1; k <= 9; k++) begin
            drive(1, 1);
            if (k == 3) chk("c3 err", 128'(misalign_err), 0);
            if (k == 4) chk("c4 err/valid", 128'({misalign_err, valid_out}), 128'b10);
        end
        chk("c9 err sticky", 128'(misalign_err), 1);

        // Reset mid-matrix discards in-flight rows.
        set_rows(8, 32'h0);
        drive(0, 1);
        for (int k = 0; k < 5; k++) drive(1, 1);
        drive(0, 1);
        chk("d reset data", data_out, '0);
        chk("d reset flags", 128'({valid_out, last_row, done, misalign_err, row_idx}), '0);
        set_rows(4, 32'h10000);
        for (int k = 1; k <= 4; k++) begin
            drive(1, 1);
            if (k < 4) chk("d no stale row", 128'(valid_out), 0);
        end
        chk("d new row idx", 128'({valid_out, row_idx}), 128'b1_00);
        chk("d new row data", data_out, 128'h00010003_00010002_00010001_00010000);

        // Randomized streams with gaps, stalls and occasional misalignment.
        for (int it = 0; it < 30; it++) begin
            n_rows = $urandom_range(1, 40);
            for (int r = 0; r < n_rows; r++) begin
                for (int j = 0; j < N; j++) rd[r][j] = $urandom;
                rv[r]    = $urandom_range(0, 9) < 7;
                rmask[r] = ($urandom_range(0, 59) == 0) ? 4'($urandom) : 4'hF;
            end
            drive(0, 1'($urandom));
            for (int k = 0; k < n_rows + N + 6; k++) drive(1, $urandom_range(0, 9) < 8);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
